sand_step_sequencer: RTL and testbench

Sequencer that advances the falling-sand simulation by one generation. It scans the cell framebuffer bottom-up and performs read-check-write moves on each sand grain. It owns the read and write ports of the 640x480 cell RAM during a pass. That RAM has one synchronous write port and one registered read port with 1-cycle latency. One pass runs per `start_i` pulse, issued by the frame-rate tick logic.

---
 rtl/sand_step_sequencer.sv | 144 ++++++++++++++
 tb/tb_sand_step_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sand_step_sequencer.sv
// rtl/sand_step_sequencer.sv - one falling-sand generation per start pulse
// Scans the cell RAM bottom-up and moves each sand grain down, down-left or down-right.
module sand_step_sequencer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] EMPTY_CODE = DATA_WIDTH'(0),
  parameter logic [DATA_WIDTH-1:0] SAND_CODE  = DATA_WIDTH'(1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rd_address_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ROW        = ADDR_WIDTH'(H_RES);
  localparam logic [ADDR_WIDTH-1:0] ROW_BACK   = ADDR_WIDTH'(2 * H_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'((V_RES - 2) * H_RES);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  localparam logic [XW-1:0]         X_LAST     = XW'(H_RES - 1);
  localparam logic [YW-1:0]         Y_START    = YW'(V_RES - 2);

  typedef enum logic [3:0] {
    IDLE, RD_C, CHK_C, CHK_D, CHK_L, CHK_R, WR_T, WR_S, DONE
  } state_t;

  state_t                  state, state_next;
  logic [XW-1:0]           x;
  logic [YW-1:0]           y;
  logic [ADDR_WIDTH-1:0]   addr, target, target_next;
  logic [ADDR_WIDTH-1:0]   below;
  logic                    advance, last_cell, is_empty;

  assign below     = addr + ROW;
  assign is_empty  = (rd_data_i == EMPTY_CODE);
  assign last_cell = (x == X_LAST) && (y == '0);

  // Each check state consumes the data of the address presented one state earlier.
  always_comb begin
    state_next  = state;
    target_next = target;
    advance     = 1'b0;
    case (state)
      IDLE:  if (start_i) state_next = RD_C;
      RD_C:  state_next = CHK_C;
      CHK_C: begin
        if (rd_data_i != SAND_CODE) advance = 1'b1;
        else                        state_next = CHK_D;
      end
      CHK_D: begin
        if (is_empty) begin
          target_next = below;
          state_next  = WR_T;
        end else begin
          state_next  = CHK_L;
        end
      end
      CHK_L: begin
        if ((x != '0) && is_empty) begin
          target_next = below - ONE;
          state_next  = WR_T;
        end else begin
          state_next  = CHK_R;
        end
      end
      CHK_R: begin
        if ((x != X_LAST) && is_empty) begin
          target_next = below + ONE;
          state_next  = WR_T;
        end else begin
          advance = 1'b1;
        end
      end
      WR_T:  state_next = WR_S;
      WR_S:  advance = 1'b1;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (advance) state_next = last_cell ? DONE : RD_C;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      addr   <= '0;
      target <= '0;
    end else begin
      state  <= state_next;
      target <= target_next;
      if (state == IDLE && start_i) begin
        x    <= '0;
        y    <= Y_START;
        addr <= START_ADDR;
      end else if (advance && !last_cell) begin
        if (x == X_LAST) begin
          x    <= '0;
          y    <= y - YW'(1);
          addr <= addr - ROW_BACK;
        end else begin
          x    <= x + XW'(1);
          addr <= addr + ONE;
        end
      end
    end
  end

  always_comb begin
    busy_o       = (state != IDLE);
    done_o       = (state == DONE);
    rd_address_o = '0;
    wr_en_o      = 1'b0;
    wr_address_o = '0;
    wr_data_o    = '0;
    case (state)
      RD_C:  rd_address_o = addr;
      CHK_C: rd_address_o = below;
      CHK_D: rd_address_o = below - ONE;
      CHK_L: rd_address_o = below + ONE;
      WR_T: begin
        wr_en_o      = 1'b1;
        wr_address_o = target;
        wr_data_o    = SAND_CODE;
      end
      WR_S: begin
        wr_en_o      = 1'b1;
        wr_address_o = addr;
        wr_data_o    = EMPTY_CODE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sand_step_sequencer.sv
// tb/tb_sand_step_sequencer.sv - bench for sand_step_sequencer on a 4x4 grid
module tb_sand_step_sequencer;

  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data;

  int errors = 0;
  int checks = 0;
  int got_q[$];
  int exp_q[$];
  int cost;
  logic [DW-1:0] mem [0:N-1];
  logic [DW-1:0] g   [0:N-1];

  always #5 clk = ~clk;

  sand_step_sequencer #(
    .H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .EMPTY_CODE(8'd0), .SAND_CODE(8'd1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done),
    .rd_address_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_address_o(wr_addr), .wr_data_o(wr_data)
  );

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_en === 1'b1) got_q.push_back(int'({wr_addr, wr_data}));
      else check("wr_bus_idle_zero", {wr_addr, wr_data}, 0);
    end
  end

  task automatic clear_grid();
    for (int i = 0; i < N; i++) mem[i] <= 8'd0;
  endtask

  task automatic set_cell(input int a, input logic [DW-1:0] v);
    mem[a] <= v;
  endtask

  // Reference: one generation on a 2-D view, listing writes and cycle cost per cell.
  task automatic model_pass();
    int c, b, t;
    for (int i = 0; i < N; i++) g[i] = mem[i];
    exp_q.delete();
    cost = 0;
    for (int yy = V - 2; yy >= 0; yy--) begin
      for (int xx = 0; xx < H; xx++) begin
        c = yy * H + xx;
        b = (yy + 1) * H + xx;
        t = -1;
        if (g[c] != 8'd1) cost += 2;
        else if (g[b] == 8'd0) begin t = b; cost += 5; end
        else if (xx > 0 && g[b-1] == 8'd0) begin t = b - 1; cost += 6; end
        else if (xx < H - 1 && g[b+1] == 8'd0) begin t = b + 1; cost += 7; end
        else cost += 5;
        if (t >= 0) begin
          g[t] = 8'd1;
          g[c] = 8'd0;
          exp_q.push_back((t << 8) | 1);
          exp_q.push_back(c << 8);
        end
      end
    end
  endtask

  task automatic run_pass(input string tag);
    int n;
    @(negedge clk);
    model_pass();
    got_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "_busy_c1"}, busy, 1);
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, cost + 1);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done}, 0);
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_cell%0d", tag, i), mem[i], g[i]);
  endtask

  initial begin
    int k, n, v;
    rst_n = 1'b0;
    start = 1'b0;
    clear_grid();
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, wr_en, rd_addr, wr_addr, wr_data}, 0);
    rst_n = 1'b1;

    run_pass("empty");

    clear_grid();
    set_cell(1, 8'd1);
    run_pass("single1");
    check("single1_first_write", (got_q.size() > 0) ? got_q[0] : -1, 32'h501);
    run_pass("single2");
    run_pass("single3");
    check("single3_at13", mem[13], 1);
    run_pass("single4");

    clear_grid();
    set_cell(9, 8'd1);
    set_cell(13, 8'd2);
    run_pass("diag_left");
    check("diag_left_12", mem[12], 1);
    check("diag_left_14", mem[14], 0);

    clear_grid();
    set_cell(8, 8'd1);
    set_cell(12, 8'd2);
    set_cell(13, 8'd2);
    run_pass("edge_block");

    clear_grid();
    set_cell(8, 8'd1);
    set_cell(12, 8'd2);
    run_pass("diag_right");
    check("diag_right_13", mem[13], 1);

    clear_grid();
    set_cell(1, 8'd1);
    set_cell(5, 8'd1);
    set_cell(9, 8'd1);
    run_pass("cascade");
    check("cascade_cells", {mem[1], mem[5], mem[9], mem[13]}, 32'h00010101);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        v = $urandom_range(0, 9);
        set_cell(i, (v < 4) ? 8'd0 : (v < 8) ? 8'd1 : (v == 8) ? 8'd2 : 8'hA5);
      end
      run_pass($sformatf("rand%0d_a", r));
      run_pass($sformatf("rand%0d_b", r));
    end

    clear_grid();
    set_cell(5, 8'd1);
    @(negedge clk);
    model_pass();
    start = 1'b1;
    @(negedge clk);
    n = 1;
    check("ctl_busy_c1", busy, 1);
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ctl_held_latency", n, cost + 1);
    @(negedge clk);
    check("ctl_idle_gap", busy, 0);
    @(negedge clk);
    check("ctl_restart", {busy, rd_addr}, {1'b1, 4'd8});
    start = 1'b0;
    k = 0;
    while (wr_en !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ctl_write_seen", wr_en, 1);
    #2 rst_n = 1'b0;
    #1 check("ctl_async_reset", {busy, done, wr_en, rd_addr, wr_addr, wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ctl_after_reset_start", {busy, rd_addr}, {1'b1, 4'd8});
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("ctl_after_reset_done", done, 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
